// File: rtl/sram_1rwnr_sync_if.sv
// ----------------------------------------------------------------------------
// sram_1rwnr_sync_if
//
// Bus bundle for sram_1rwnr_sync: one read/write port (port 0) and
// NUM_RPORTS read-only lanes (port 1). Clock and reset are not part of the
// bundle and stay plain ports on the memory.
//
// Signals (direction as seen by the memory, i.e. the slave modport):
//   busy       out  high while the clear sweep runs; requests are ignored
//   csb0       in   port 0 chip select, active low
//   web0       in   port 0 write enable, active low
//   wmask0     in   port 0 byte-lane write mask, active high
//   addr0      in   port 0 address
//   din0       in   port 0 write data
//   dout0      out  port 0 read data (holds until the next completed read)
//   dout0_vld  out  one-cycle pulse when dout0 is updated
//   csb1       in   per-lane chip select, active low
//   addr1      in   packed lane addresses, lane k = [k*ADDR_WIDTH +: ADDR_WIDTH]
//   dout1      out  packed lane read data, lane k = [k*DATA_WIDTH +: DATA_WIDTH]
//   dout1_vld  out  per-lane one-cycle pulse when that lane's dout1 is updated
// ----------------------------------------------------------------------------
interface sram_1rwnr_sync_if #(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int ADDR_WIDTH = 9,
  parameter int NUM_RPORTS = 1
);

  localparam int NUM_WMASKS = DATA_WIDTH / BYTE_WIDTH;

  logic                             busy;

  logic                             csb0;
  logic                             web0;
  logic [NUM_WMASKS-1:0]            wmask0;
  logic [ADDR_WIDTH-1:0]            addr0;
  logic [DATA_WIDTH-1:0]            din0;
  logic [DATA_WIDTH-1:0]            dout0;
  logic                             dout0_vld;

  logic [NUM_RPORTS-1:0]            csb1;
  logic [NUM_RPORTS*ADDR_WIDTH-1:0] addr1;
  logic [NUM_RPORTS*DATA_WIDTH-1:0] dout1;
  logic [NUM_RPORTS-1:0]            dout1_vld;

  // Requester side.
  modport master (
    input  busy,
    output csb0, web0, wmask0, addr0, din0,
    input  dout0, dout0_vld,
    output csb1, addr1,
    input  dout1, dout1_vld
  );

  // Memory side.
  modport slave (
    output busy,
    input  csb0, web0, wmask0, addr0, din0,
    output dout0, dout0_vld,
    input  csb1, addr1,
    output dout1, dout1_vld
  );

endinterface

// File: rtl/sram_1rwnr_sync.sv
// ----------------------------------------------------------------------------
// sram_1rwnr_sync
//
// Synthesizable single-clock behavioural SRAM with one read/write port
// (port 0) and NUM_RPORTS independent read-only lanes (port 1).
//
//   - Byte-lane masked writes on port 0.
//   - Read latency 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1), fully
//     pipelined, with a one-cycle valid strobe per accepted read.
//   - Read-during-write on a lane hitting addr0: old word (RDW_MODE=0) or
//     the mask-merged new word (RDW_MODE=1).
//   - Optional clear sweep after reset (CLEAR_ON_RESET=1) that zeroes every
//     word, one per cycle, while busy is high.
//
// Ports:
//   clk  in   single clock, rising edge
//   rst  in   synchronous active-high reset
//   bus  slave modport of sram_1rwnr_sync_if (see that file for signals)
//
// Parameters of the connected interface must match DATA_WIDTH, BYTE_WIDTH,
// ADDR_WIDTH and NUM_RPORTS here.
// ----------------------------------------------------------------------------
module sram_1rwnr_sync #(
  parameter int DATA_WIDTH     = 32,
  parameter int BYTE_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 9,
  parameter int NUM_RPORTS     = 1,
  parameter int OUT_REG        = 0,
  parameter int RDW_MODE       = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                clk,
  input  logic                rst,
  sram_1rwnr_sync_if.slave    bus
);

  localparam int NUM_WMASKS = DATA_WIDTH / BYTE_WIDTH;
  localparam int RAM_DEPTH  = 2 ** ADDR_WIDTH;

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } state_e;

  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;

  // NOTE: the array has no reset branch; a reset on every word would turn the
  // storage into flops and prevent RAM inference. Zeroing is done by the sweep.
  word_t mem [RAM_DEPTH];

  // --------------------------------------------------------------------------
  // Clear sweep FSM
  // --------------------------------------------------------------------------
  logic  sweep_busy;
  logic  sweep_we;
  addr_t sweep_addr;

  generate
    if (CLEAR_ON_RESET != 0) begin : g_clear
      state_e state_q, state_d;
      addr_t  cnt_q,   cnt_d;

      // NOTE: clocked state uses non-blocking assignments so every flop
      // samples the pre-edge value of its inputs regardless of block order.
      always_ff @(posedge clk) begin
        if (rst) begin
          state_q <= ST_CLEAR;
          cnt_q   <= '0;
        end else begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
        end
      end

      // NOTE: every output of a combinational block gets a default first so
      // no path leaves it unassigned and no latch is inferred.
      always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_CLEAR) begin
          cnt_d = cnt_q + 1'b1;
          // The last word is written on this edge; RUN takes effect next cycle.
          if (cnt_q == addr_t'(RAM_DEPTH - 1)) begin
            state_d = ST_RUN;
          end
        end
      end

      assign sweep_busy = (state_q == ST_CLEAR);
      // The sweep only writes on cycles where reset is released.
      assign sweep_we   = sweep_busy & ~rst;
      assign sweep_addr = cnt_q;
    end else begin : g_no_clear
      assign sweep_busy = 1'b0;
      assign sweep_we   = 1'b0;
      assign sweep_addr = '0;
    end
  endgenerate

  assign bus.busy = sweep_busy;

  // --------------------------------------------------------------------------
  // Request decode: nothing is accepted under reset or during the sweep.
  // --------------------------------------------------------------------------
  logic                  accept;
  logic                  wr_en;
  logic                  rd0_en;
  logic [NUM_RPORTS-1:0] rd1_en;

  assign accept = ~rst & ~sweep_busy;
  assign wr_en  = accept & ~bus.csb0 & ~bus.web0;
  assign rd0_en = accept & ~bus.csb0 &  bus.web0;
  assign rd1_en = {NUM_RPORTS{accept}} & ~bus.csb1;

  // --------------------------------------------------------------------------
  // Storage write path (sweep has priority; the two never overlap since
  // wr_en is already masked by busy).
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (sweep_we) begin
      mem[sweep_addr] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NUM_WMASKS; i++) begin
        if (bus.wmask0[i]) begin
          mem[bus.addr0][i*BYTE_WIDTH +: BYTE_WIDTH] <= bus.din0[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  // Word as it will look after this cycle's write: new bytes where the mask
  // is set, old bytes elsewhere. Used for write-through lane reads.
  word_t wr_merged;

  always_comb begin
    wr_merged = mem[bus.addr0];
    for (int i = 0; i < NUM_WMASKS; i++) begin
      if (bus.wmask0[i]) begin
        wr_merged[i*BYTE_WIDTH +: BYTE_WIDTH] = bus.din0[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  // Per-lane read word with the read-during-write policy applied.
  word_t lane_rd_word [NUM_RPORTS];

  always_comb begin
    for (int k = 0; k < NUM_RPORTS; k++) begin
      lane_rd_word[k] = mem[bus.addr1[k*ADDR_WIDTH +: ADDR_WIDTH]];
      if ((RDW_MODE != 0) && wr_en && (bus.addr1[k*ADDR_WIDTH +: ADDR_WIDTH] == bus.addr0)) begin
        lane_rd_word[k] = wr_merged;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read stage 1: array capture. Data registers load only on an accepted
  // read so the output holds between reads; reset clears data and valids,
  // which also drops any read in flight.
  // --------------------------------------------------------------------------
  word_t                 s1_dout0_q;
  logic                  s1_vld0_q;
  word_t                 s1_dout1_q [NUM_RPORTS];
  logic [NUM_RPORTS-1:0] s1_vld1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_dout0_q <= '0;
      s1_vld0_q  <= 1'b0;
      s1_vld1_q  <= '0;
      for (int k = 0; k < NUM_RPORTS; k++) begin
        s1_dout1_q[k] <= '0;
      end
    end else begin
      s1_vld0_q <= rd0_en;
      s1_vld1_q <= rd1_en;
      if (rd0_en) begin
        s1_dout0_q <= mem[bus.addr0];
      end
      for (int k = 0; k < NUM_RPORTS; k++) begin
        if (rd1_en[k]) begin
          s1_dout1_q[k] <= lane_rd_word[k];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Optional read stage 2: output register.
  // --------------------------------------------------------------------------
  word_t                 out_dout0;
  logic                  out_vld0;
  word_t                 out_dout1 [NUM_RPORTS];
  logic [NUM_RPORTS-1:0] out_vld1;

  generate
    if (OUT_REG != 0) begin : g_out_reg
      word_t                 s2_dout0_q;
      logic                  s2_vld0_q;
      word_t                 s2_dout1_q [NUM_RPORTS];
      logic [NUM_RPORTS-1:0] s2_vld1_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          s2_dout0_q <= '0;
          s2_vld0_q  <= 1'b0;
          s2_vld1_q  <= '0;
          for (int k = 0; k < NUM_RPORTS; k++) begin
            s2_dout1_q[k] <= '0;
          end
        end else begin
          s2_vld0_q <= s1_vld0_q;
          s2_vld1_q <= s1_vld1_q;
          if (s1_vld0_q) begin
            s2_dout0_q <= s1_dout0_q;
          end
          for (int k = 0; k < NUM_RPORTS; k++) begin
            if (s1_vld1_q[k]) begin
              s2_dout1_q[k] <= s1_dout1_q[k];
            end
          end
        end
      end

      assign out_dout0 = s2_dout0_q;
      assign out_vld0  = s2_vld0_q;
      assign out_dout1 = s2_dout1_q;
      assign out_vld1  = s2_vld1_q;
    end else begin : g_no_out_reg
      assign out_dout0 = s1_dout0_q;
      assign out_vld0  = s1_vld0_q;
      assign out_dout1 = s1_dout1_q;
      assign out_vld1  = s1_vld1_q;
    end
  endgenerate

  assign bus.dout0     = out_dout0;
  assign bus.dout0_vld = out_vld0;
  assign bus.dout1_vld = out_vld1;

  always_comb begin
    bus.dout1 = '0;
    for (int k = 0; k < NUM_RPORTS; k++) begin
      bus.dout1[k*DATA_WIDTH +: DATA_WIDTH] = out_dout1[k];
    end
  end

  // --------------------------------------------------------------------------
  // Bench-only backdoor helpers, addressed by byte (word index = addr >> 2).
  // Nothing in this module calls them, so they add no hardware.
  // --------------------------------------------------------------------------
  function automatic word_t readWord(input logic [31:0] byte_addr);
    logic [31:0] word_idx;
    word_idx = byte_addr >> 2;
    return mem[word_idx[ADDR_WIDTH-1:0]];
  endfunction

  task automatic writeWord(input logic [31:0] byte_addr, input word_t val);
    logic [31:0] word_idx;
    word_idx = byte_addr >> 2;
    mem[word_idx[ADDR_WIDTH-1:0]] <= val;
  endtask

endmodule

// File: tb/tb_sram_1rwnr_sync.sv
// ----------------------------------------------------------------------------
// tb_sram_1rwnr_sync
//
// Two instances share one stimulus stream:
//   dut_a: OUT_REG=0, RDW_MODE=0 (latency 1, old data on read-during-write)
//   dut_b: OUT_REG=1, RDW_MODE=1 (latency 2, merged data on read-during-write)
// Both use a 16-word x 32-bit array, three read lanes and the clear sweep.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_sram_1rwnr_sync;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int NR = 3;

  logic clk = 1'b0;
  logic rst;

  int n_tests = 0;
  int n_fail  = 0;
  int busy_cycles;
  int b_vld_run;

  always #5 clk = ~clk;

  sram_1rwnr_sync_if #(.DATA_WIDTH(DW), .BYTE_WIDTH(8), .ADDR_WIDTH(AW), .NUM_RPORTS(NR)) bus_a ();
  sram_1rwnr_sync_if #(.DATA_WIDTH(DW), .BYTE_WIDTH(8), .ADDR_WIDTH(AW), .NUM_RPORTS(NR)) bus_b ();

  sram_1rwnr_sync #(
    .DATA_WIDTH(DW), .BYTE_WIDTH(8), .ADDR_WIDTH(AW), .NUM_RPORTS(NR),
    .OUT_REG(0), .RDW_MODE(0), .CLEAR_ON_RESET(1)
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  sram_1rwnr_sync #(
    .DATA_WIDTH(DW), .BYTE_WIDTH(8), .ADDR_WIDTH(AW), .NUM_RPORTS(NR),
    .OUT_REG(1), .RDW_MODE(1), .CLEAR_ON_RESET(1)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lane_of(input logic [NR*DW-1:0] v, input int k);
    return v[k*DW +: DW];
  endfunction

  function automatic logic [31:0] pat(input int i);
    return 32'hA500_0000 + 32'(i) * 32'h0001_0203;
  endfunction

  task automatic idle();
    bus_a.csb0 = 1'b1; bus_a.web0 = 1'b1; bus_a.wmask0 = '0; bus_a.addr0 = '0; bus_a.din0 = '0;
    bus_a.csb1 = '1;   bus_a.addr1 = '0;
    bus_b.csb0 = 1'b1; bus_b.web0 = 1'b1; bus_b.wmask0 = '0; bus_b.addr0 = '0; bus_b.din0 = '0;
    bus_b.csb1 = '1;   bus_b.addr1 = '0;
  endtask

  task automatic p0(input logic csb, input logic web, input logic [3:0] mask,
                    input logic [AW-1:0] addr, input logic [DW-1:0] din);
    bus_a.csb0 = csb; bus_a.web0 = web; bus_a.wmask0 = mask; bus_a.addr0 = addr; bus_a.din0 = din;
    bus_b.csb0 = csb; bus_b.web0 = web; bus_b.wmask0 = mask; bus_b.addr0 = addr; bus_b.din0 = din;
  endtask

  task automatic lane(input int k, input logic csb, input logic [AW-1:0] addr);
    bus_a.csb1[k] = csb; bus_a.addr1[k*AW +: AW] = addr;
    bus_b.csb1[k] = csb; bus_b.addr1[k*AW +: AW] = addr;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle();
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_busy_a",    32'(bus_a.busy), 32'd1);
    check("rst_dout0_a",   bus_a.dout0, 32'h0);
    check("rst_vld0_a",    32'(bus_a.dout0_vld), 32'd0);
    check("rst_vld1_b",    32'(bus_b.dout1_vld), 32'd0);
    check("rst_dout1_b_2", lane_of(bus_b.dout1, 2), 32'h0);

    // Sweep interrupted at count 8, then a full restart of 16 cycles
    rst = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy_a", 32'(bus_a.busy), 32'd1);
    rst = 1'b0;
    busy_cycles = 0;
    while (bus_a.busy === 1'b1 && busy_cycles < 40) begin
      busy_cycles++;
      @(negedge clk);
    end
    check("sweep_len_a", 32'(busy_cycles), 32'd16);
    check("sweep_done_b", 32'(bus_b.busy), 32'd0);

    // Every word reads back as zero
    for (int i = 0; i < 16; i++) begin
      p0(1'b0, 1'b1, 4'h0, 4'(i), 32'h0);
      @(negedge clk);
      check($sformatf("zero_vld_%0d", i), 32'(bus_a.dout0_vld), 32'd1);
      check($sformatf("zero_dat_%0d", i), bus_a.dout0, 32'h0);
    end

    // Masked write over a full word, then read on port 0
    p0(1'b0, 1'b0, 4'hF, 4'd3, 32'h1122_3344);
    @(negedge clk);
    p0(1'b0, 1'b0, 4'b0101, 4'd3, 32'hAABB_CCDD);
    @(negedge clk);
    check("wr_no_vld_a", 32'(bus_a.dout0_vld), 32'd0);
    p0(1'b0, 1'b1, 4'h0, 4'd3, 32'h0);
    @(negedge clk);
    idle();
    check("mask_vld_a_l1",   32'(bus_a.dout0_vld), 32'd1);
    check("mask_dat_a_l1",   bus_a.dout0, 32'h11BB_33DD);
    check("mask_vld_b_l1",   32'(bus_b.dout0_vld), 32'd0);
    @(negedge clk);
    check("mask_vld_a_l2",   32'(bus_a.dout0_vld), 32'd0);
    check("mask_hold_a",     bus_a.dout0, 32'h11BB_33DD);
    check("mask_vld_b_l2",   32'(bus_b.dout0_vld), 32'd1);
    check("mask_dat_b_l2",   bus_b.dout0, 32'h11BB_33DD);
    @(negedge clk);
    check("mask_vld_b_l3",   32'(bus_b.dout0_vld), 32'd0);

    // Read-during-write on lane 0, then a plain read of the same address
    p0(1'b0, 1'b0, 4'hF, 4'd5, 32'hCAFE_F00D);
    lane(0, 1'b0, 4'd5);
    @(negedge clk);
    p0(1'b1, 1'b1, 4'h0, 4'd0, 32'h0);
    check("rdw_wr_vld0_a", 32'(bus_a.dout0_vld), 32'd0);
    check("rdw_old_a",     lane_of(bus_a.dout1, 0), 32'h0);
    check("rdw_vld1_a",    32'(bus_a.dout1_vld), 32'b001);
    @(negedge clk);
    lane(0, 1'b1, 4'd5);
    check("rdw_next_a",    lane_of(bus_a.dout1, 0), 32'hCAFE_F00D);
    check("rdw_next_vld_a", 32'(bus_a.dout1_vld), 32'b001);
    check("rdw_new_b",     lane_of(bus_b.dout1, 0), 32'hCAFE_F00D);
    check("rdw_vld1_b",    32'(bus_b.dout1_vld), 32'b001);
    @(negedge clk);
    check("rdw_next_b",    lane_of(bus_b.dout1, 0), 32'hCAFE_F00D);
    check("rdw_next_vld_b", 32'(bus_b.dout1_vld), 32'b001);
    check("rdw_idle_vld_a", 32'(bus_a.dout1_vld), 32'b000);

    // Three lanes read 1, 1, 7 in the same cycle
    p0(1'b0, 1'b0, 4'hF, 4'd1, 32'h0101_0101);
    @(negedge clk);
    p0(1'b0, 1'b0, 4'hF, 4'd7, 32'h0707_0707);
    @(negedge clk);
    p0(1'b1, 1'b1, 4'h0, 4'd0, 32'h0);
    lane(0, 1'b0, 4'd1);
    lane(1, 1'b0, 4'd1);
    lane(2, 1'b0, 4'd7);
    @(negedge clk);
    idle();
    check("ml_vld1_a",  32'(bus_a.dout1_vld), 32'b111);
    check("ml_l0_a",    lane_of(bus_a.dout1, 0), 32'h0101_0101);
    check("ml_l1_a",    lane_of(bus_a.dout1, 1), 32'h0101_0101);
    check("ml_l2_a",    lane_of(bus_a.dout1, 2), 32'h0707_0707);
    check("ml_dout0_a", bus_a.dout0, 32'h11BB_33DD);
    check("ml_vld0_a",  32'(bus_a.dout0_vld), 32'd0);
    @(negedge clk);
    check("ml_vld1_b",  32'(bus_b.dout1_vld), 32'b111);
    check("ml_l1_b",    lane_of(bus_b.dout1, 1), 32'h0101_0101);
    check("ml_l2_b",    lane_of(bus_b.dout1, 2), 32'h0707_0707);
    check("ml_dout0_b", bus_b.dout0, 32'h11BB_33DD);

    // Fill with a pattern, then 16 back-to-back port 0 reads
    for (int i = 0; i < 16; i++) begin
      p0(1'b0, 1'b0, 4'hF, 4'(i), pat(i));
      @(negedge clk);
    end
    b_vld_run = 0;
    for (int cyc = 0; cyc < 18; cyc++) begin
      if (cyc < 16) p0(1'b0, 1'b1, 4'h0, 4'(cyc), 32'h0);
      else          idle();
      @(negedge clk);
      if (cyc < 16) begin
        check($sformatf("b2b_dat_a_%0d", cyc), bus_a.dout0, pat(cyc));
      end
      if (cyc >= 1 && cyc <= 16) begin
        check($sformatf("b2b_vld_b_%0d", cyc), 32'(bus_b.dout0_vld), 32'd1);
        check($sformatf("b2b_dat_b_%0d", cyc), bus_b.dout0, pat(cyc - 1));
      end else begin
        check($sformatf("b2b_vld_b_%0d", cyc), 32'(bus_b.dout0_vld), 32'd0);
      end
      if (bus_b.dout0_vld === 1'b1) b_vld_run++;
    end
    check("b2b_vld_count_b", 32'(b_vld_run), 32'd16);

    // Reset in the middle of back-to-back reads
    p0(1'b0, 1'b1, 4'h0, 4'd2, 32'h0);
    @(negedge clk);
    p0(1'b0, 1'b1, 4'h0, 4'd3, 32'h0);
    @(negedge clk);
    check("pre_rst_dat_a", bus_a.dout0, pat(3));
    p0(1'b0, 1'b1, 4'h0, 4'd4, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_rd_dat_a",  bus_a.dout0, 32'h0);
    check("rst_rd_vld_a",  32'(bus_a.dout0_vld), 32'd0);
    check("rst_rd_dat_b",  bus_b.dout0, 32'h0);
    check("rst_rd_vld_b",  32'(bus_b.dout0_vld), 32'd0);
    check("rst_rd_busy_b", 32'(bus_b.busy), 32'd1);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("post_rst_vld_a_%0d", i), 32'(bus_a.dout0_vld), 32'd0);
      check($sformatf("post_rst_vld_b_%0d", i), 32'(bus_b.dout0_vld), 32'd0);
      check($sformatf("post_rst_dat_b_%0d", i), bus_b.dout0, 32'h0);
    end
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_1rwnr_sync.md
Name: sram_1rwnr_sync

Overview:
- Synthesizable, single-clock behavioural SRAM. One read/write port (port 0) and NUM_RPORTS read-only ports (port 1 lanes).
- Parametrised successor to the fixed 32x512 1rw1r macro model. Width, byte size, depth and read-port count are generalised.
- Adds selectable read latency, a defined read-during-write policy, per-port read-valid strobes and an optional clear-on-reset sweep.
- Used as the on-chip instruction/data/register-file store wherever a hard macro is not instantiated.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of BYTE_WIDTH.
- BYTE_WIDTH, 8, bits per write-mask lane; NUM_WMASKS = DATA_WIDTH/BYTE_WIDTH.
- ADDR_WIDTH, 9, address bits; RAM_DEPTH = 2**ADDR_WIDTH.
- NUM_RPORTS, 1, number of read-only ports, 1..4.
- OUT_REG, 0, 0 = read latency 1 cycle, 1 = extra output register, latency 2 cycles.
- RDW_MODE, 0, read port hitting the address written in the same cycle: 0 = old data, 1 = new (mask-merged) data.
- CLEAR_ON_RESET, 1, 1 = zero every word after reset, 0 = no sweep (contents X in simulation).

Ports:
- clk, input, 1, the single clock; everything is sampled on its rising edge.
- rst, input, 1, synchronous active-high reset.
- busy, output, 1, high while the clear sweep runs; requests are ignored while busy is high.
- csb0, input, 1, port 0 active-low chip select.
- web0, input, 1, port 0 active-low write enable.
- wmask0, input, NUM_WMASKS, port 0 byte-lane write mask, active high.
- addr0, input, ADDR_WIDTH, port 0 address.
- din0, input, DATA_WIDTH, port 0 write data.
- dout0, output, DATA_WIDTH, port 0 read data.
- dout0_vld, output, 1, one-cycle pulse when dout0 is updated.
- csb1, input, NUM_RPORTS, active-low chip select, one bit per read port.
- addr1, input, NUM_RPORTS*ADDR_WIDTH, read addresses; lane k is bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- dout1, output, NUM_RPORTS*DATA_WIDTH, read data; packed the same way as addr1.
- dout1_vld, output, NUM_RPORTS, per-lane one-cycle pulse when that lane's dout1 is updated.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values:
  - dout0, dout1 = 0.
  - dout0_vld, dout1_vld = 0.
  - Sweep counter = 0.
  - busy = CLEAR_ON_RESET.
  - Memory array is not reset directly.
- FSM (present only when CLEAR_ON_RESET=1), states CLEAR and RUN:
  - rst forces CLEAR with counter 0.
  - In CLEAR, each cycle with rst low writes 0 to mem[counter], then counter+1.
  - After writing RAM_DEPTH-1, go to RUN; busy falls in the following cycle. Sweep length is exactly RAM_DEPTH cycles after rst deasserts.
  - rst during CLEAR restarts the sweep at 0.
  - rst during RUN aborts pending reads: pipeline valids are cleared and dout is not updated.
- When CLEAR_ON_RESET=0: state is fixed at RUN and busy is tied 0.
- Requests are accepted only in RUN with rst low. While busy, csb/web are ignored and outputs hold.
- Write (csb0=0, web0=0):
  - At the edge, mem[addr0] lane i <= din0 lane i for every wmask0[i]=1.
  - wmask0=0 means no change.
  - dout0 is not updated and dout0_vld stays 0.
- Read port 0 (csb0=0, web0=1): mem[addr0] is captured. dout0 and dout0_vld are presented after the latency below.
- Read lane k (csb1[k]=0): same as port 0, on lane k. Lanes are independent, and any lanes may share an address.
- Latency:
  - OUT_REG=0: data and vld appear 1 cycle after the accepting edge.
  - OUT_REG=1: data and vld appear 2 cycles after the accepting edge.
  - Fully pipelined: back-to-back reads return one per cycle, in order.
- Hold: dout keeps its last value until the next completed read on that port. vld is high for exactly one cycle per accepted read.
- Read-during-write, lane k reading addr0 in the same cycle as a write:
  - RDW_MODE=0 returns the pre-write word.
  - RDW_MODE=1 returns the merged word: din0 in lanes with mask=1, old data in the others.
- No illegal addresses: depth is a power of two and all address values are valid.
- Debug helpers: readWord(byte_addr) returns mem[byte_addr>>2]; writeWord(byte_addr,val) sets mem[byte_addr>>2]. Both are for test benches only and are outside the synthesis path.

Test Plan:
1. Clear sweep (CLEAR_ON_RESET=1, ADDR_WIDTH=4) -> after rst deasserts, busy is high for 16 cycles. A read of every address then returns 0x00000000.
2. Masked write (wmask0=4'b0101, din0=0xAABBCCDD, addr 3, over 0x11223344), then read on port 0 -> 0x11BB33DD. It arrives 1 cycle after the read edge at OUT_REG=0 and 2 cycles at OUT_REG=1; dout0_vld pulses once.
3. Read-during-write on lane 0 at addr 5 (old 0x0, new 0xCAFEF00D, full mask) -> RDW_MODE=0 gives 0x00000000, RDW_MODE=1 gives 0xCAFEF00D. A read of addr 5 in the next cycle gives 0xCAFEF00D in both modes.
4. NUM_RPORTS=3, lanes reading addresses 1,1,7 in the same cycle -> all three vld pulse together with the correct words. dout0 keeps its prior value.
5. rst asserted at sweep count 8 -> counter restarts and busy stays high for a full 16 cycles after release. rst during back-to-back reads -> no vld pulses after reset, and dout=0.
6. 16 back-to-back reads at OUT_REG=1 -> 16 consecutive vld cycles, data in address order, no bubbles.
